// File: rtl/issue_scheduler.sv
// issue_scheduler: collapsing issue queue that selects up to two oldest-ready entries per cycle.
// Define ISSUE_SCHED_IN_ORDER_EN to restrict select to the queue head (entry 0, then entry 1).
module issue_scheduler #(
    parameter int DEPTH     = 8,
    parameter int REG_W     = 5,
    parameter int PAYLOAD_W = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       disp_inst1_valid,
    input  logic [REG_W-1:0]           disp_inst1_src1,
    input  logic                       disp_inst1_src1_ready,
    input  logic [REG_W-1:0]           disp_inst1_src2,
    input  logic                       disp_inst1_src2_ready,
    input  logic [REG_W-1:0]           disp_inst1_dest,
    input  logic                       disp_inst1_rf_we,
    input  logic [PAYLOAD_W-1:0]       disp_inst1_payload,
    input  logic                       disp_inst2_valid,
    input  logic [REG_W-1:0]           disp_inst2_src1,
    input  logic                       disp_inst2_src1_ready,
    input  logic [REG_W-1:0]           disp_inst2_src2,
    input  logic                       disp_inst2_src2_ready,
    input  logic [REG_W-1:0]           disp_inst2_dest,
    input  logic                       disp_inst2_rf_we,
    input  logic [PAYLOAD_W-1:0]       disp_inst2_payload,
    output logic                       disp_ready,
    input  logic                       iss_ready,
    output logic                       iss_inst1_valid,
    output logic [REG_W-1:0]           iss_inst1_dest,
    output logic                       iss_inst1_rf_we,
    output logic [PAYLOAD_W-1:0]       iss_inst1_payload,
    output logic                       iss_inst2_valid,
    output logic [REG_W-1:0]           iss_inst2_dest,
    output logic                       iss_inst2_rf_we,
    output logic [PAYLOAD_W-1:0]       iss_inst2_payload,
    output logic [REG_W-1:0]           sel_inst1_dest,
    output logic [REG_W-1:0]           sel_inst2_dest,
    input  logic [REG_W-1:0]           wb_inst1_dest,
    input  logic [REG_W-1:0]           wb_inst2_dest,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [REG_W-1:0]     src1;
        logic                 src1_rdy;
        logic [REG_W-1:0]     src2;
        logic                 src2_rdy;
        logic [REG_W-1:0]     dest;
        logic                 rf_we;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_W-1:0]     dest;
        logic                 rf_we;
        logic [PAYLOAD_W-1:0] payload;
    } iss_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    iss_t             iss1_q, iss1_d, iss2_q, iss2_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] rdy, sel_m;
    logic             sel1_v, sel2_v;
    logic [IW-1:0]    sel1_i, sel2_i;
    logic             acc1, acc2;
    ent_t             new1, new2;

    // Register 0 is always ready; idle broadcasts are 0 so they never match a real source.
    function automatic logic hit(input logic [REG_W-1:0] r);
        return r == '0 || r == sel_inst1_dest || r == sel_inst2_dest ||
               r == wb_inst1_dest || r == wb_inst2_dest;
    endfunction

    always_comb begin
        sel_m  = '0;
        sel1_v = 1'b0;
        sel2_v = 1'b0;
        sel1_i = '0;
        sel2_i = '0;
        for (int i = 0; i < DEPTH; i++) rdy[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
        if (iss_ready && !flush) begin
`ifdef ISSUE_SCHED_IN_ORDER_EN
            sel1_v = rdy[0];
            sel2_v = rdy[0] && rdy[1];
            sel2_i = IW'(1);
`else
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i] && !sel1_v) begin
                    sel1_v = 1'b1;
                    sel1_i = IW'(i);
                end else if (rdy[i] && !sel2_v) begin
                    sel2_v = 1'b1;
                    sel2_i = IW'(i);
                end
            end
`endif
            // Slot 2 first so an unused slot 2 aliasing index 0 cannot mask slot 1.
            sel_m[sel2_i] = sel2_v;
            sel_m[sel1_i] = sel1_v;
        end
        sel_inst1_dest = (sel1_v && ent_q[sel1_i].rf_we) ? ent_q[sel1_i].dest : '0;
        sel_inst2_dest = (sel2_v && ent_q[sel2_i].rf_we) ? ent_q[sel2_i].dest : '0;
    end

    assign disp_ready = count_q <= CW'(DEPTH - 2);
    assign acc1       = disp_ready && disp_inst1_valid && !flush;
    assign acc2       = acc1 && disp_inst2_valid;

    always_comb begin
        new1 = ent_t'{valid: 1'b1, src1: disp_inst1_src1,
                      src1_rdy: disp_inst1_src1_ready || hit(disp_inst1_src1),
                      src2: disp_inst1_src2,
                      src2_rdy: disp_inst1_src2_ready || hit(disp_inst1_src2),
                      dest: disp_inst1_dest, rf_we: disp_inst1_rf_we, payload: disp_inst1_payload};
        new2 = ent_t'{valid: 1'b1, src1: disp_inst2_src1,
                      src1_rdy: disp_inst2_src1_ready || hit(disp_inst2_src1),
                      src2: disp_inst2_src2,
                      src2_rdy: disp_inst2_src2_ready || hit(disp_inst2_src2),
                      dest: disp_inst2_dest, rf_we: disp_inst2_rf_we, payload: disp_inst2_payload};
    end

    // Survivors collapse toward index 0 in age order; new dispatches land behind them.
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !sel_m[i]) begin
                ent_d[IW'(k)]          = ent_q[i];
                ent_d[IW'(k)].src1_rdy = ent_q[i].src1_rdy || hit(ent_q[i].src1);
                ent_d[IW'(k)].src2_rdy = ent_q[i].src2_rdy || hit(ent_q[i].src2);
                k++;
            end
        end
        if (acc1) begin
            ent_d[IW'(k)] = new1;
            k++;
        end
        if (acc2) begin
            ent_d[IW'(k)] = new2;
            k++;
        end
        count_d = CW'(k);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    always_comb begin
        iss1_d = iss1_q;
        iss2_d = iss2_q;
        if (flush) begin
            iss1_d = '0;
            iss2_d = '0;
        end else if (iss_ready) begin
            iss1_d = '0;
            iss2_d = '0;
            if (sel1_v) iss1_d = iss_t'{1'b1, ent_q[sel1_i].dest, ent_q[sel1_i].rf_we, ent_q[sel1_i].payload};
            if (sel2_v) iss2_d = iss_t'{1'b1, ent_q[sel2_i].dest, ent_q[sel2_i].rf_we, ent_q[sel2_i].payload};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            iss1_q  <= '0;
            iss2_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            iss1_q  <= iss1_d;
            iss2_q  <= iss2_d;
            count_q <= count_d;
        end
    end

    assign iss_inst1_valid   = iss1_q.valid;
    assign iss_inst1_dest    = iss1_q.dest;
    assign iss_inst1_rf_we   = iss1_q.rf_we;
    assign iss_inst1_payload = iss1_q.payload;
    assign iss_inst2_valid   = iss2_q.valid;
    assign iss_inst2_dest    = iss2_q.dest;
    assign iss_inst2_rf_we   = iss2_q.rf_we;
    assign iss_inst2_payload = iss2_q.payload;
    assign count             = count_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed self-checking bench for issue_scheduler (DEPTH=8).
// Expectations follow ISSUE_SCHED_IN_ORDER_EN when it is defined for the build.
module tb_issue_scheduler;
`ifdef ISSUE_SCHED_IN_ORDER_EN
    localparam bit INO = 1'b1;
`else
    localparam bit INO = 1'b0;
`endif

    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0;
    logic        disp_inst1_valid, disp_inst1_src1_ready, disp_inst1_src2_ready, disp_inst1_rf_we;
    logic [4:0]  disp_inst1_src1, disp_inst1_src2, disp_inst1_dest;
    logic [31:0] disp_inst1_payload;
    logic        disp_inst2_valid, disp_inst2_src1_ready, disp_inst2_src2_ready, disp_inst2_rf_we;
    logic [4:0]  disp_inst2_src1, disp_inst2_src2, disp_inst2_dest;
    logic [31:0] disp_inst2_payload;
    logic        disp_ready, iss_ready;
    logic        iss_inst1_valid, iss_inst1_rf_we, iss_inst2_valid, iss_inst2_rf_we;
    logic [4:0]  iss_inst1_dest, iss_inst2_dest, sel_inst1_dest, sel_inst2_dest;
    logic [31:0] iss_inst1_payload, iss_inst2_payload;
    logic [4:0]  wb_inst1_dest, wb_inst2_dest;
    logic [3:0]  count;
    int          errors = 0, checks = 0;

    issue_scheduler #(.DEPTH(8), .REG_W(5), .PAYLOAD_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .disp_inst1_valid(disp_inst1_valid), .disp_inst1_src1(disp_inst1_src1),
        .disp_inst1_src1_ready(disp_inst1_src1_ready), .disp_inst1_src2(disp_inst1_src2),
        .disp_inst1_src2_ready(disp_inst1_src2_ready), .disp_inst1_dest(disp_inst1_dest),
        .disp_inst1_rf_we(disp_inst1_rf_we), .disp_inst1_payload(disp_inst1_payload),
        .disp_inst2_valid(disp_inst2_valid), .disp_inst2_src1(disp_inst2_src1),
        .disp_inst2_src1_ready(disp_inst2_src1_ready), .disp_inst2_src2(disp_inst2_src2),
        .disp_inst2_src2_ready(disp_inst2_src2_ready), .disp_inst2_dest(disp_inst2_dest),
        .disp_inst2_rf_we(disp_inst2_rf_we), .disp_inst2_payload(disp_inst2_payload),
        .disp_ready(disp_ready), .iss_ready(iss_ready),
        .iss_inst1_valid(iss_inst1_valid), .iss_inst1_dest(iss_inst1_dest),
        .iss_inst1_rf_we(iss_inst1_rf_we), .iss_inst1_payload(iss_inst1_payload),
        .iss_inst2_valid(iss_inst2_valid), .iss_inst2_dest(iss_inst2_dest),
        .iss_inst2_rf_we(iss_inst2_rf_we), .iss_inst2_payload(iss_inst2_payload),
        .sel_inst1_dest(sel_inst1_dest), .sel_inst2_dest(sel_inst2_dest),
        .wb_inst1_dest(wb_inst1_dest), .wb_inst2_dest(wb_inst2_dest), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic d1(input logic [4:0] s1, input logic r1, input logic [4:0] s2, input logic r2,
                      input logic [4:0] d, input logic [31:0] pl);
        disp_inst1_valid = 1'b1; disp_inst1_src1 = s1; disp_inst1_src1_ready = r1;
        disp_inst1_src2 = s2; disp_inst1_src2_ready = r2; disp_inst1_dest = d;
        disp_inst1_rf_we = 1'b1; disp_inst1_payload = pl;
    endtask

    task automatic d2(input logic [4:0] s1, input logic r1, input logic [4:0] s2, input logic r2,
                      input logic [4:0] d, input logic [31:0] pl);
        disp_inst2_valid = 1'b1; disp_inst2_src1 = s1; disp_inst2_src1_ready = r1;
        disp_inst2_src2 = s2; disp_inst2_src2_ready = r2; disp_inst2_dest = d;
        disp_inst2_rf_we = 1'b1; disp_inst2_payload = pl;
    endtask

    task automatic idle();
        disp_inst1_valid = 1'b0; disp_inst1_src1 = '0; disp_inst1_src1_ready = 1'b0;
        disp_inst1_src2 = '0; disp_inst1_src2_ready = 1'b0; disp_inst1_dest = '0;
        disp_inst1_rf_we = 1'b0; disp_inst1_payload = '0;
        disp_inst2_valid = 1'b0; disp_inst2_src1 = '0; disp_inst2_src1_ready = 1'b0;
        disp_inst2_src2 = '0; disp_inst2_src2_ready = 1'b0; disp_inst2_dest = '0;
        disp_inst2_rf_we = 1'b0; disp_inst2_payload = '0;
        wb_inst1_dest = '0; wb_inst2_dest = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        iss_ready = 1'b1;
        idle();
        #2;
        chk("rst_count", count, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_iss1_valid", iss_inst1_valid, 0);
        chk("rst_iss1_dest", iss_inst1_dest, 0);
        chk("rst_sel1", sel_inst1_dest, 0);
        #10 resetn = 1'b1;
        tick();
        // basic add r3 <- r1, r2
        d1(1, 1, 2, 1, 3, 32'hA);
        #1 chk("s1_disp_ready", disp_ready, 1);
        tick(); idle(); #1;
        chk("s1_sel1_t1", sel_inst1_dest, 3);
        chk("s1_count_t1", count, 1);
        chk("s1_iss1_valid_t1", iss_inst1_valid, 0);
        tick();
        chk("s1_iss1_valid_t2", iss_inst1_valid, 1);
        chk("s1_iss1_dest_t2", iss_inst1_dest, 3);
        chk("s1_iss1_payload", iss_inst1_payload, 32'hA);
        chk("s1_iss2_valid", iss_inst2_valid, 0);
        chk("s1_count_t2", count, 0);
        // back-to-back dependent via select wakeup at dispatch
        d1(1, 1, 2, 1, 3, 32'hB);
        tick();
        d1(3, 0, 0, 0, 4, 32'hC);
        #1 chk("s2_sel_prod", sel_inst1_dest, 3);
        tick(); idle(); #1;
        chk("s2_sel_dep", sel_inst1_dest, 4);
        chk("s2_iss_prod", iss_inst1_dest, 3);
        tick();
        chk("s2_iss_dep_valid", iss_inst1_valid, 1);
        chk("s2_iss_dep_dest", iss_inst1_dest, 4);
        chk("s2_count", count, 0);
        // waiting entry woken by writeback
        d1(3, 0, 0, 1, 5, 32'hD);
        tick(); idle(); #1;
        chk("s2b_sel_wait", sel_inst1_dest, 0);
        chk("s2b_count", count, 1);
        tick();
        chk("s2b_iss_none", iss_inst1_valid, 0);
        wb_inst2_dest = 3;
        #1 chk("s2b_sel_wake_cycle", sel_inst1_dest, 0);
        tick(); wb_inst2_dest = 0; #1;
        chk("s2b_sel_after_wake", sel_inst1_dest, 5);
        tick();
        chk("s2b_iss_dest", iss_inst1_dest, 5);
        chk("s2b_iss_valid", iss_inst1_valid, 1);
        chk("s2b_count_end", count, 0);
        // blocked head, younger ready entries
        iss_ready = 1'b0;
        d1(7, 0, 0, 1, 8, 32'h8); d2(1, 1, 0, 1, 9, 32'h9);
        tick(); idle();
        d1(2, 1, 0, 1, 10, 32'h10);
        tick(); idle(); iss_ready = 1'b1; #1;
        chk("s3_count", count, 3);
        chk("s3_sel1", sel_inst1_dest, INO ? 0 : 9);
        chk("s3_sel2", sel_inst2_dest, INO ? 0 : 10);
        tick();
        chk("s3_iss1_valid", iss_inst1_valid, INO ? 0 : 1);
        chk("s3_iss1_dest", iss_inst1_dest, INO ? 0 : 9);
        chk("s3_iss2_dest", iss_inst2_dest, INO ? 0 : 10);
        chk("s3_count_after", count, INO ? 3 : 1);
        wb_inst1_dest = 7;
        #1 chk("s3_sel_wb_cycle", sel_inst1_dest, 0);
        tick(); wb_inst1_dest = 0; #1;
        chk("s3_sel_head", sel_inst1_dest, 8);
        chk("s3_sel_head2", sel_inst2_dest, INO ? 9 : 0);
        tick();
        chk("s3_iss_head", iss_inst1_dest, 8);
        chk("s3_iss2_valid_head", iss_inst2_valid, INO ? 1 : 0);
        chk("s3_count_head", count, INO ? 1 : 0);
        tick(); tick();
        chk("s3_drain", count, 0);
        // fill to DEPTH-1
        iss_ready = 1'b0;
        d1(0, 1, 0, 1, 11, 32'h11); d2(20, 0, 0, 1, 12, 32'h12);
        tick();
        d1(20, 0, 0, 1, 13, 32'h13); d2(20, 0, 0, 1, 14, 32'h14);
        tick();
        d1(20, 0, 0, 1, 15, 32'h15); d2(20, 0, 0, 1, 16, 32'h16);
        tick(); idle();
        d1(20, 0, 0, 1, 17, 32'h17);
        tick(); idle(); #1;
        chk("s4_count_full", count, 7);
        chk("s4_disp_ready_full", disp_ready, 0);
        d1(0, 1, 0, 1, 21, 32'h21); iss_ready = 1'b1;
        #1 chk("s4_sel_full", sel_inst1_dest, 11);
        chk("s4_disp_ready_issue", disp_ready, 0);
        tick(); idle(); iss_ready = 1'b0; wb_inst1_dest = 20; #1;
        chk("s4_count_after", count, 6);
        chk("s4_disp_ready_after", disp_ready, 1);
        chk("s4_iss_dest", iss_inst1_dest, 11);
        tick(); wb_inst1_dest = 0;
        // stalled execute stage with ready entries
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s5_sel_hold", sel_inst1_dest, 0);
            chk("s5_count_hold", count, 6);
            chk("s5_iss_hold", iss_inst1_dest, 11);
            chk("s5_iss_valid_hold", iss_inst1_valid, 1);
            tick();
        end
        iss_ready = 1'b1;
        #1 chk("s5_sel1_release", sel_inst1_dest, 12);
        chk("s5_sel2_release", sel_inst2_dest, 13);
        tick(); iss_ready = 1'b0;
        chk("s5_count_release", count, 4);
        chk("s5_iss2_release", iss_inst2_dest, 13);
        d1(0, 1, 0, 1, 22, 32'h22);
        tick(); idle(); #1;
        chk("s6_count_pre", count, 5);
        // flush with concurrent dispatch and ready entries
        flush = 1'b1; iss_ready = 1'b1;
        d1(0, 1, 0, 1, 23, 32'h23);
        #1 chk("s6_sel1_flush", sel_inst1_dest, 0);
        chk("s6_sel2_flush", sel_inst2_dest, 0);
        tick(); flush = 1'b0; idle(); #1;
        chk("s6_count", count, 0);
        chk("s6_iss1_valid", iss_inst1_valid, 0);
        chk("s6_iss2_valid", iss_inst2_valid, 0);
        chk("s6_disp_ready", disp_ready, 1);
        // asynchronous reset mid-operation
        iss_ready = 1'b0;
        d1(0, 1, 0, 1, 24, 32'h24); d2(0, 1, 0, 1, 25, 32'h25);
        tick(); idle();
        d1(0, 1, 0, 1, 26, 32'h26);
        tick(); idle(); iss_ready = 1'b1;
        tick();
        chk("s7_count_pre", count, 1);
        chk("s7_iss_pre", iss_inst1_dest, 24);
        resetn = 1'b0;
        #2;
        chk("s7_count_async", count, 0);
        chk("s7_iss1_valid_async", iss_inst1_valid, 0);
        chk("s7_iss1_dest_async", iss_inst1_dest, 0);
        chk("s7_iss2_valid_async", iss_inst2_valid, 0);
        chk("s7_disp_ready_async", disp_ready, 1);
        chk("s7_sel_async", sel_inst1_dest, 0);
        #2 resetn = 1'b1;
        tick();
        chk("s7_count_post", count, 0);
        chk("s7_iss_post", iss_inst1_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
